// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
// Functions operate on a fixed maximum width so they serve any N up to MAX_N.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_N = 64;

  // Index width for N requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Round-robin mask bit: requester bit_i lies strictly after the last-served ptr.
  function automatic logic rr_mask(input int bit_i, input int ptr);
    return bit_i > ptr;
  endfunction

endpackage

// File: rtl/arb_wrr_pick.sv
// Combinational winner selection: round robin starting after ptr (holder last),
// or fixed priority with the lowest index winning.
module arb_wrr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  for (genvar i = 0; i < N; i++) begin : g_mask
    assign mask[i] = rr_mask(i, int'(ptr));
  end

  // With nothing above ptr, the unmasked lowest bit is the wrap-around winner.
  always_comb begin
    masked = req & mask;
    src    = (!mode && (|masked)) ? masked : req;
    win_oh = src & (~src + N'(1));
  end

  assign win_idx = IDX_W'(onehot_to_idx(MAX_N'(win_oh)));
  assign any     = |req;

endmodule

// File: rtl/arb_wrr_lock.sv
// Registered weighted round-robin arbiter with per-packet grant locking and a
// runtime-selectable fixed-priority mode.
module arb_wrr_lock
  import arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int WEIGHT_W  = 4,
  parameter int RESET_PTR = N - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  mode,
  input  logic                  xfer,
  input  logic                  xfer_last,
  output logic [N-1:0]          gnt,
  output logic                  gnt_valid,
  output logic [$clog2(N)-1:0]  gnt_idx,
  output arb_state_e            state_dbg
);

  localparam int IDX_W = $clog2(N);

  // Handshake: a beat completes on a cycle with xfer=1 (valid&ready at the
  // resource); xfer_last marks the final beat and is ignored without xfer.

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic                 arb_en;

  logic [N-1:0]         pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [WEIGHT_W-1:0]  w_arr [N];
  logic [WEIGHT_W-1:0]  w_sel;
  logic [WEIGHT_W-1:0]  w_load;

  arb_wrr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .mode    (mode),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  for (genvar i = 0; i < N; i++) begin : g_weight
    assign w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
  end

  assign w_sel  = w_arr[pick_idx];
  assign w_load = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    arb_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) arb_en = 1'b1;
      end
      LOCKED: begin
        if (xfer && xfer_last) begin
          if (!mode && (credit_q > WEIGHT_W'(1)) && req[ptr_q]) begin
            credit_d = credit_q - WEIGHT_W'(1);
          end else if (pick_any) begin
            arb_en = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh arbitration always reloads credit from the winner's own weight.
    if (arb_en) begin
      state_d  = LOCKED;
      ptr_d    = pick_idx;
      credit_d = w_load;
      gnt_d    = pick_oh;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(RESET_PTR);
      credit_q <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && arb_en) assert ((pick_oh & ~req) == '0);
    assert ($onehot0(gnt_q));
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = ptr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_arb_wrr_lock.sv
// Self-checking bench for arb_wrr_lock: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_arb_wrr_lock;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic            mode;
  logic            xfer;
  logic            xfer_last;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [1:0]      gnt_idx;
  arb_state_e      state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [N-1:0] exp_q[$];

  // Behavioural model: grant holder index, credit left, locked flag.
  int m_idx;
  int m_credit;
  bit m_locked;

  arb_wrr_lock #(.N(N), .WEIGHT_W(WW), .RESET_PTR(N-1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .weight    (weight),
    .mode      (mode),
    .xfer      (xfer),
    .xfer_last (xfer_last),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int weight_of(input int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_arbitrate();
    int w;
    w = -1;
    if (mode) begin
      for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
    end else begin
      for (int k = N; k >= 1; k--) if (req[(m_idx + k) % N]) w = (m_idx + k) % N;
    end
    m_idx    = w;
    m_credit = weight_of(w);
    m_locked = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_idx = N - 1; m_credit = 0; m_locked = 1'b0;
    end else if (!m_locked) begin
      if (req != 0) model_arbitrate();
    end else if (xfer && xfer_last) begin
      if (!mode && m_credit > 1 && req[m_idx]) m_credit = m_credit - 1;
      else if (req != 0) model_arbitrate();
      else m_locked = 1'b0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_gnt", int'(gnt), m_locked ? (1 << m_idx) : 0);
      check("model_gnt_valid", int'(gnt_valid), int'(m_locked));
      check("model_gnt_idx", int'(gnt_idx), m_idx);
      check("model_state", int'(state_dbg), m_locked ? int'(LOCKED) : int'(IDLE));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = '0; xfer = 1'b0; xfer_last = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [N-1:0] rr_seq [5];
    int cnt [N];
    logic [N-1:0] e;

    rst = 1'b1; req = '0; weight = 16'h1111; mode = 1'b0;
    xfer = 1'b0; xfer_last = 1'b0;
    step(); step();
    chk_en = 1'b1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_valid", int'(gnt_valid), 0);
    check("reset_idx", int'(gnt_idx), 3);
    rst = 1'b0;

    // Basic round robin, single-beat packets every cycle
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
    req = 4'hf; xfer = 1'b1; xfer_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_seq", int'(gnt), int'(rr_seq[k]));
    end
    req = '0;
    step();
    check("rr_release_gnt", int'(gnt), 0);
    check("rr_release_idx", int'(gnt_idx), 0);

    // Weighting 3/1/1/2
    pulse_reset();
    weight = 16'h2113; req = 4'hf; xfer = 1'b1; xfer_last = 1'b1;
    exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      e = exp_q.pop_front();
      check("wrr_order", int'(gnt), int'(e));
      if (k < 7) cnt[gnt_idx]++;
    end
    check("wrr_cnt0", cnt[0], 3);
    check("wrr_cnt1", cnt[1], 1);
    check("wrr_cnt2", cnt[2], 1);
    check("wrr_cnt3", cnt[3], 2);
    pulse_reset();
    weight = 16'h1111;

    // Lock for a 4-beat packet while req[0] drops
    req = 4'b0011;
    step(); check("lock_b0", int'(gnt), 1);
    xfer = 1'b1; xfer_last = 1'b0;
    step(); check("lock_b1", int'(gnt), 1);
    req = 4'b0010;
    step(); check("lock_b2", int'(gnt), 1);
    step(); check("lock_b3", int'(gnt), 1);
    xfer_last = 1'b1;
    step(); check("lock_rotate", int'(gnt), 2);
    req = '0;
    step(); check("lock_release", int'(gnt), 0);
    check("lock_release_idx", int'(gnt_idx), 1);
    xfer = 1'b0; xfer_last = 1'b0;

    // Fixed priority
    pulse_reset();
    mode = 1'b1; weight = 16'h4444; req = 4'b1010; xfer = 1'b1; xfer_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); check("fixed_gnt1", int'(gnt), 2);
    end
    req = 4'b1011;
    step(); check("fixed_gnt0", int'(gnt), 1);
    req = '0;
    step();
    xfer = 1'b0; xfer_last = 1'b0; mode = 1'b0; weight = 16'h1111;

    // Idle after requester 3, then wrap to 0
    pulse_reset();
    req = 4'b1000;
    step(); check("idle_gnt3", int'(gnt), 8);
    xfer = 1'b1; xfer_last = 1'b1; req = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      xfer = 1'b0; xfer_last = 1'b0;
      check("idle_gnt", int'(gnt), 0);
      check("idle_idx", int'(gnt_idx), 3);
    end
    req = 4'b1001;
    step(); check("wrap_gnt", int'(gnt), 1);

    // Reset mid-packet
    xfer = 1'b1; xfer_last = 1'b0;
    step();
    rst = 1'b1; req = 4'b0100;
    step();
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_idx", int'(gnt_idx), 3);
    rst = 1'b0; xfer = 1'b0;
    step(); check("midrst_regrant", int'(gnt), 4);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) weight = 16'($urandom_range(0, 65535));
      xfer      = 1'($urandom_range(0, 1));
      xfer_last = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0; req = '0; xfer = 1'b0; xfer_last = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
